// File: rtl/fmul_36bit_norm.sv
// fmul_36bit_norm
//   Normalise / round / pack back end of a 36-bit floating-point multiplier
//   (1 sign, 11 exponent bits at bias 1023, 24 fraction bits). Takes the raw
//   25x25 significand product plus operand class flags and produces the
//   packed result with IEEE-style exception flags, two register stages deep.
//
// Ports
//   iCLOCK               clock, rising edge
//   iRESET_SYNC          synchronous active-high reset
//   iDATA_REQ            upstream product valid
//   oDATA_BUSY           backpressure to upstream (mirrors iDATA_BUSY)
//   iDATA_SIGN           product sign
//   iDATA_EXP[12:0]      biased product exponent, two's complement
//   iDATA_FRACT[49:0]    raw significand product, hidden bits included
//   iDATA_EXCEPT_*       operand A/B class flags (exp all-0/all-1, fract all-0)
//   oDATA_VALID          result valid
//   iDATA_BUSY           downstream backpressure
//   oDATA_DATA[35:0]     {sign, exp[10:0], fract[23:0]}
//   oDATA_EXCEPT[3:0]    {invalid, overflow, underflow, inexact}
module fmul_36bit_norm (
  input  logic        iCLOCK,
  input  logic        iRESET_SYNC,
  input  logic        iDATA_REQ,
  output logic        oDATA_BUSY,
  input  logic        iDATA_SIGN,
  input  logic [12:0] iDATA_EXP,
  input  logic [49:0] iDATA_FRACT,
  input  logic        iDATA_EXCEPT_EXP_A0,
  input  logic        iDATA_EXCEPT_EXP_B0,
  input  logic        iDATA_EXCEPT_EXP_A1,
  input  logic        iDATA_EXCEPT_EXP_B1,
  input  logic        iDATA_EXCEPT_FRACT_A0,
  input  logic        iDATA_EXCEPT_FRACT_B0,
  output logic        oDATA_VALID,
  input  logic        iDATA_BUSY,
  output logic [35:0] oDATA_DATA,
  output logic [3:0]  oDATA_EXCEPT
);

  // Result class decided in S1; the QNAN class covers both NaN propagation
  // and the invalid inf*zero case, told apart by s1_invalid.
  typedef enum logic [1:0] {
    CLS_NORMAL,
    CLS_QNAN,
    CLS_INF,
    CLS_ZERO
  } cls_t;

  localparam logic [35:0] QNAN_WORD = 36'h7FF800000;

  // ---------------------------------------------------------------------
  // S1 combinational: classify operands and normalise the product
  // ---------------------------------------------------------------------
  logic               nan_a, nan_b, inf_a, inf_b, zero_a, zero_b;
  cls_t               cls_c;
  logic               invalid_c;
  logic [23:0]        mant_c;
  logic               guard_c;
  logic               sticky_c;
  logic signed [13:0] e_c;

  assign zero_a = iDATA_EXCEPT_EXP_A0;
  assign zero_b = iDATA_EXCEPT_EXP_B0;
  assign inf_a  = iDATA_EXCEPT_EXP_A1 &  iDATA_EXCEPT_FRACT_A0;
  assign inf_b  = iDATA_EXCEPT_EXP_B1 &  iDATA_EXCEPT_FRACT_B0;
  assign nan_a  = iDATA_EXCEPT_EXP_A1 & ~iDATA_EXCEPT_FRACT_A0;
  assign nan_b  = iDATA_EXCEPT_EXP_B1 & ~iDATA_EXCEPT_FRACT_B0;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    cls_c     = CLS_NORMAL;
    invalid_c = 1'b0;
    if (nan_a || nan_b) begin
      cls_c = CLS_QNAN;
    end else if ((inf_a && zero_b) || (inf_b && zero_a)) begin
      cls_c     = CLS_QNAN;
      invalid_c = 1'b1;
    end else if (inf_a || inf_b) begin
      cls_c = CLS_INF;
    end else if (zero_a || zero_b) begin
      cls_c = CLS_ZERO;
    end
  end

  // The product of two [1,2) significands lies in [1,4); bit 49 set means
  // the product is >= 2 and the binary point moves one place left.
  always_comb begin
    if (iDATA_FRACT[49]) begin
      mant_c   = iDATA_FRACT[48:25];
      guard_c  = iDATA_FRACT[24];
      sticky_c = |iDATA_FRACT[23:0];
      e_c      = $signed({iDATA_EXP[12], iDATA_EXP}) + 14'sd1;
    end else begin
      mant_c   = iDATA_FRACT[47:24];
      guard_c  = iDATA_FRACT[23];
      sticky_c = |iDATA_FRACT[22:0];
      e_c      = $signed({iDATA_EXP[12], iDATA_EXP});
    end
  end

  // ---------------------------------------------------------------------
  // S1 registers
  // ---------------------------------------------------------------------
  logic               s1_valid;
  logic               s1_sign;
  cls_t               s1_cls;
  logic               s1_invalid;
  logic [23:0]        s1_mant;
  logic               s1_guard;
  logic               s1_sticky;
  logic signed [13:0] s1_e;

  // Both stages advance together; downstream busy freezes the whole pipe.
  logic advance;
  assign advance    = ~iDATA_BUSY;
  assign oDATA_BUSY = iDATA_BUSY;

  always_ff @(posedge iCLOCK) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (iRESET_SYNC) begin
      // NOTE: the datapath registers are reset too, not just the valids,
      // because the outputs must read zero after reset.
      s1_valid   <= 1'b0;
      s1_sign    <= 1'b0;
      s1_cls     <= CLS_NORMAL;
      s1_invalid <= 1'b0;
      s1_mant    <= '0;
      s1_guard   <= 1'b0;
      s1_sticky  <= 1'b0;
      s1_e       <= '0;
    end else if (advance) begin
      s1_valid   <= iDATA_REQ;
      s1_sign    <= iDATA_SIGN;
      s1_cls     <= cls_c;
      s1_invalid <= invalid_c;
      s1_mant    <= mant_c;
      s1_guard   <= guard_c;
      s1_sticky  <= sticky_c;
      s1_e       <= e_c;
    end
  end

  // ---------------------------------------------------------------------
  // S2 combinational: round to nearest even, range check, pack
  // ---------------------------------------------------------------------
  logic               round_up;
  logic               carry;
  logic [23:0]        mant_r;
  logic signed [13:0] e_r;
  logic [35:0]        data_c;
  logic [3:0]         except_c;

  assign round_up      = s1_guard & (s1_sticky | s1_mant[0]);
  // An all-ones mantissa rounding up wraps to zero; the carry bumps E.
  assign {carry, mant_r} = {1'b0, s1_mant} + {24'd0, round_up};
  assign e_r           = s1_e + $signed({13'd0, carry});

  always_comb begin
    data_c   = '0;
    except_c = '0;
    unique case (s1_cls)
      CLS_QNAN: begin
        data_c   = QNAN_WORD;
        except_c = {s1_invalid, 3'b000};
      end
      CLS_INF: begin
        data_c = {s1_sign, 11'h7FF, 24'd0};
      end
      CLS_ZERO: begin
        data_c = {s1_sign, 35'd0};
      end
      default: begin
        if (e_r >= 14'sd2047) begin
          data_c   = {s1_sign, 11'h7FF, 24'd0};
          except_c = 4'b0101;
        end else if (e_r <= 14'sd0) begin
          data_c   = {s1_sign, 35'd0};
          except_c = 4'b0011;
        end else begin
          data_c   = {s1_sign, e_r[10:0], mant_r};
          except_c = {3'b000, s1_guard | s1_sticky};
        end
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // S2 registers drive the outputs directly
  // ---------------------------------------------------------------------
  always_ff @(posedge iCLOCK) begin
    if (iRESET_SYNC) begin
      oDATA_VALID  <= 1'b0;
      oDATA_DATA   <= '0;
      oDATA_EXCEPT <= '0;
    end else if (advance) begin
      oDATA_VALID  <= s1_valid;
      oDATA_DATA   <= data_c;
      oDATA_EXCEPT <= except_c;
    end
  end

endmodule

// File: tb/tb_fmul_36bit_norm.sv
// tb_fmul_36bit_norm
//   Directed bench for fmul_36bit_norm. A behavioural model computes the
//   rounded result from the product value with integer arithmetic; a single
//   negedge process checks every valid output against a queue of expected
//   results and checks the accept-to-valid latency. Directed vectors also
//   carry hand-computed literal results.
module tb_fmul_36bit_norm;

  logic        iCLOCK = 1'b0;
  logic        iRESET_SYNC;
  logic        iDATA_REQ;
  logic        oDATA_BUSY;
  logic        iDATA_SIGN;
  logic [12:0] iDATA_EXP;
  logic [49:0] iDATA_FRACT;
  logic        iDATA_EXCEPT_EXP_A0, iDATA_EXCEPT_EXP_B0;
  logic        iDATA_EXCEPT_EXP_A1, iDATA_EXCEPT_EXP_B1;
  logic        iDATA_EXCEPT_FRACT_A0, iDATA_EXCEPT_FRACT_B0;
  logic        oDATA_VALID;
  logic        iDATA_BUSY;
  logic [35:0] oDATA_DATA;
  logic [3:0]  oDATA_EXCEPT;

  fmul_36bit_norm dut (
    .iCLOCK               (iCLOCK),
    .iRESET_SYNC          (iRESET_SYNC),
    .iDATA_REQ            (iDATA_REQ),
    .oDATA_BUSY           (oDATA_BUSY),
    .iDATA_SIGN           (iDATA_SIGN),
    .iDATA_EXP            (iDATA_EXP),
    .iDATA_FRACT          (iDATA_FRACT),
    .iDATA_EXCEPT_EXP_A0  (iDATA_EXCEPT_EXP_A0),
    .iDATA_EXCEPT_EXP_B0  (iDATA_EXCEPT_EXP_B0),
    .iDATA_EXCEPT_EXP_A1  (iDATA_EXCEPT_EXP_A1),
    .iDATA_EXCEPT_EXP_B1  (iDATA_EXCEPT_EXP_B1),
    .iDATA_EXCEPT_FRACT_A0(iDATA_EXCEPT_FRACT_A0),
    .iDATA_EXCEPT_FRACT_B0(iDATA_EXCEPT_FRACT_B0),
    .oDATA_VALID          (oDATA_VALID),
    .iDATA_BUSY           (iDATA_BUSY),
    .oDATA_DATA           (oDATA_DATA),
    .oDATA_EXCEPT         (oDATA_EXCEPT)
  );

  always #5 iCLOCK = ~iCLOCK;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: actual=%h required=%h", name, act, req);
    end
  endtask

  // Flags packed as {A0, B0, A1, B1, FRACT_A0, FRACT_B0}.
  localparam logic [5:0] FL_NONE    = 6'b000000;
  localparam logic [5:0] FL_INF_A_Z = 6'b011010; // A inf, B zero
  localparam logic [5:0] FL_NAN_A   = 6'b001000; // A exp all-one, fract nonzero
  localparam logic [5:0] FL_INF_A   = 6'b001010; // A inf, B normal
  localparam logic [5:0] FL_ZERO_B  = 6'b010000; // B zero, A normal
  localparam logic [5:0] FL_NAN_A_Z = 6'b011000; // A NaN, B zero

  // Behavioural model: returns {except, data}.
  function automatic logic [39:0] model(input logic sign, input logic [12:0] e_in,
                                        input logic [49:0] f, input logic [5:0] fl);
    logic   a0, b0, a1, b1, fa0, fb0;
    logic   nan_a, nan_b, inf_a, inf_b;
    longint fv, q, rem, half, m;
    int     sh, e;
    logic   up;
    {a0, b0, a1, b1, fa0, fb0} = fl;
    nan_a = a1 && !fa0;
    nan_b = b1 && !fb0;
    inf_a = a1 && fa0;
    inf_b = b1 && fb0;
    if (nan_a || nan_b) return {4'b0000, 36'h7FF800000};
    if ((inf_a && b0) || (inf_b && a0)) return {4'b1000, 36'h7FF800000};
    if (inf_a || inf_b) return {4'b0000, sign, 11'h7FF, 24'd0};
    if (a0 || b0) return {4'b0000, sign, 35'd0};
    // Split the product into kept bits q and discarded remainder rem.
    fv   = longint'(f);
    sh   = f[49] ? 25 : 24;
    q    = fv >> sh;
    rem  = fv - (q << sh);
    half = longint'(1) << (sh - 1);
    up   = (rem > half) || (rem == half && q[0]);
    e    = int'($signed(e_in)) + sh - 24;
    m    = q % (longint'(1) << 24);
    m    = m + longint'(up);
    if (m == (longint'(1) << 24)) begin
      m = 0;
      e = e + 1;
    end
    if (e >= 2047) return {4'b0101, sign, 11'h7FF, 24'd0};
    if (e <= 0) return {4'b0011, sign, 35'd0};
    return {3'b000, rem != 0, sign, e[10:0], m[23:0]};
  endfunction

  // Scoreboard of accepted items, with accept cycle for latency checks.
  typedef struct {
    logic [35:0] d;
    logic [3:0]  x;
    int          cyc;
    int          stall;
    bit          seen;
  } exp_t;

  exp_t exp_q[$];
  int   neg_cyc  = 0;
  int   busy_cnt = 0;

  always @(negedge iCLOCK) begin
    exp_t        it;
    logic [39:0] mres;
    neg_cyc++;
    if (oDATA_VALID === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_valid", 64'(oDATA_VALID), 64'd0);
      end else begin
        it = exp_q[0];
        check("out_data", 64'(oDATA_DATA), 64'(it.d));
        check("out_except", 64'(oDATA_EXCEPT), 64'(it.x));
        if (!it.seen) begin
          check("latency", 64'(neg_cyc), 64'(it.cyc + 2 + (busy_cnt - it.stall)));
          exp_q[0].seen = 1'b1;
        end
        if (!iDATA_BUSY) void'(exp_q.pop_front());
      end
    end
    if (iDATA_BUSY) busy_cnt++;
    if (iRESET_SYNC) begin
      exp_q.delete();
    end else if (iDATA_REQ && !iDATA_BUSY) begin
      mres = model(iDATA_SIGN, iDATA_EXP, iDATA_FRACT,
                   {iDATA_EXCEPT_EXP_A0, iDATA_EXCEPT_EXP_B0, iDATA_EXCEPT_EXP_A1,
                    iDATA_EXCEPT_EXP_B1, iDATA_EXCEPT_FRACT_A0, iDATA_EXCEPT_FRACT_B0});
      exp_q.push_back('{d: mres[35:0], x: mres[39:36], cyc: neg_cyc, stall: busy_cnt, seen: 1'b0});
    end
  end

  // Directed vector table with hand-computed results.
  typedef struct {
    string       name;
    logic        sign;
    logic [12:0] e;
    logic [49:0] f;
    logic [5:0]  fl;
    logic [35:0] d;
    logic [3:0]  x;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input string name, input logic sign, input logic [12:0] e,
                     input logic [49:0] f, input logic [5:0] fl,
                     input logic [35:0] d, input logic [3:0] x);
    vecs.push_back('{name: name, sign: sign, e: e, f: f, fl: fl, d: d, x: x});
  endtask

  task automatic apply(input vec_t v);
    iDATA_SIGN = v.sign;
    iDATA_EXP  = v.e;
    iDATA_FRACT = v.f;
    {iDATA_EXCEPT_EXP_A0, iDATA_EXCEPT_EXP_B0, iDATA_EXCEPT_EXP_A1,
     iDATA_EXCEPT_EXP_B1, iDATA_EXCEPT_FRACT_A0, iDATA_EXCEPT_FRACT_B0} = v.fl;
  endtask

  // One isolated transaction: valid must be low one cycle after accept and
  // high with the literal result two cycles after accept.
  task automatic run_vec(input vec_t v);
    @(posedge iCLOCK); #1;
    apply(v);
    iDATA_BUSY = 1'b0;
    iDATA_REQ  = 1'b1;
    @(posedge iCLOCK); #1;
    iDATA_REQ = 1'b0;
    check({v.name, "_not_early"}, 64'(oDATA_VALID), 64'd0);
    @(posedge iCLOCK);
    @(negedge iCLOCK);
    check({v.name, "_valid"}, 64'(oDATA_VALID), 64'd1);
    check({v.name, "_data"}, 64'(oDATA_DATA), 64'(v.d));
    check({v.name, "_except"}, 64'(oDATA_EXCEPT), 64'(v.x));
  endtask

  task automatic drain(input string name);
    for (int k = 0; k < 20 && exp_q.size() != 0; k++) @(negedge iCLOCK);
    check(name, 64'(exp_q.size()), 64'd0);
  endtask

  localparam logic [49:0] ONE48 = 50'd1 << 48;
  localparam logic [49:0] ONE49 = 50'd1 << 49;

  initial begin
    #200000;
    $display("FAIL global_timeout: actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t v;
    int   idx;
    int   guard;

    add("one_x_one",   1'b0, 13'h3FF, ONE48, FL_NONE, 36'h3FF000000, 4'b0000);
    add("1p5_x_1p5",   1'b0, 13'h3FF, 50'd9 << 46, FL_NONE, 36'h400200000, 4'b0000);
    add("tie_even",    1'b0, 13'h3FF, ONE48 + (50'd1 << 23), FL_NONE, 36'h3FF000000, 4'b0001);
    add("tie_odd",     1'b0, 13'h3FF, ONE48 + (50'd1 << 24) + (50'd1 << 23), FL_NONE,
        36'h3FF000002, 4'b0001);
    add("round_carry", 1'b0, 13'h3FF, ONE49 - (50'd1 << 23), FL_NONE, 36'h400000000, 4'b0001);
    add("sticky_only", 1'b0, 13'h3FF, ONE48 + 50'd1, FL_NONE, 36'h3FF000000, 4'b0001);
    add("overflow",    1'b0, 13'd2046, ONE49, FL_NONE, 36'h7FF000000, 4'b0101);
    add("rnd_ovf",     1'b0, 13'd2046, ONE49 - (50'd1 << 23), FL_NONE, 36'h7FF000000, 4'b0101);
    add("max_exp",     1'b0, 13'd2045, ONE49, FL_NONE, 36'h7FE000000, 4'b0000);
    add("underflow",   1'b1, 13'h1FFF, ONE48, FL_NONE, 36'h800000000, 4'b0011);
    add("exp_zero",    1'b0, 13'd0, ONE48, FL_NONE, 36'h000000000, 4'b0011);
    add("min_exp",     1'b0, 13'd0, ONE49, FL_NONE, 36'h001000000, 4'b0000);
    add("inf_x_zero",  1'b1, 13'h3FF, ONE48, FL_INF_A_Z, 36'h7FF800000, 4'b1000);
    add("nan_a",       1'b1, 13'h3FF, ONE48, FL_NAN_A, 36'h7FF800000, 4'b0000);
    add("nan_x_zero",  1'b0, 13'h3FF, ONE48, FL_NAN_A_Z, 36'h7FF800000, 4'b0000);
    add("inf_x_norm",  1'b1, 13'h3FF, ONE48, FL_INF_A, 36'hFFF000000, 4'b0000);
    add("zero_x_norm", 1'b1, 13'h3FF, ONE48, FL_ZERO_B, 36'h800000000, 4'b0000);

    // Reset with request high and busy low: nothing may be accepted.
    iRESET_SYNC = 1'b1;
    iDATA_BUSY  = 1'b0;
    iDATA_REQ   = 1'b1;
    apply(vecs[0]);
    repeat (3) @(posedge iCLOCK);
    #1;
    iRESET_SYNC = 1'b0;
    iDATA_REQ   = 1'b0;
    @(negedge iCLOCK);
    check("reset_valid", 64'(oDATA_VALID), 64'd0);
    check("reset_data", 64'(oDATA_DATA), 64'd0);
    check("reset_except", 64'(oDATA_EXCEPT), 64'd0);

    // Busy passes straight through.
    iDATA_BUSY = 1'b1; #1;
    check("busy_passthru_1", 64'(oDATA_BUSY), 64'd1);
    iDATA_BUSY = 1'b0; #1;
    check("busy_passthru_0", 64'(oDATA_BUSY), 64'd0);

    foreach (vecs[i]) run_vec(vecs[i]);
    drain("directed_drain");

    // Back-to-back stream with busy high for three cycles mid-stream.
    idx   = 0;
    guard = 0;
    @(posedge iCLOCK); #1;
    while (idx < vecs.size() && guard < 100) begin
      iDATA_BUSY = (guard >= 3 && guard < 6);
      apply(vecs[idx]);
      iDATA_REQ = 1'b1;
      @(posedge iCLOCK); #1;
      if (!iDATA_BUSY) idx++;
      guard++;
    end
    iDATA_REQ  = 1'b0;
    iDATA_BUSY = 1'b0;
    drain("stream_drain");

    // Reset in the middle of a stream: everything in flight is discarded.
    @(posedge iCLOCK); #1;
    for (int i = 0; i < 4; i++) begin
      apply(vecs[i + 1]);
      iDATA_REQ = 1'b1;
      @(posedge iCLOCK); #1;
    end
    iRESET_SYNC = 1'b1;
    @(posedge iCLOCK); #1;
    check("midreset_valid", 64'(oDATA_VALID), 64'd0);
    check("midreset_data", 64'(oDATA_DATA), 64'd0);
    iRESET_SYNC = 1'b0;
    iDATA_REQ   = 1'b0;
    @(posedge iCLOCK); #1;
    check("postreset_idle", 64'(oDATA_VALID), 64'd0);
    v = vecs[3];
    v.name = "after_reset";
    run_vec(v);
    drain("final_drain");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
